// File: rtl/hamming_encoder_tx.sv
`timescale 1ns/1ps
// hamming_encoder_tx
//   Serial extended-Hamming (SECDED) encoder/transmitter. A parallel message is
//   encoded into an 8-, 16- or 32-bit codeword on the accepting edge and shifted
//   out LSB first (position 0 first), one bit per clock.
//   Codeword layout: data bits fill the non-power-of-two positions 3..N-1 in
//   ascending order; position 2^k is the XOR of the other positions with bit k
//   set; position 0 makes the overall parity even.
//   DATA_WIDTH must be 32; the 8- and 16-bit codes are runtime modes.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_data_in   message, LSB-aligned; bits above the mode's data width are ignored
//   i_code_sel  00=8 (4 data), 01=16 (11 data), 10=32 (26 data), 11=reserved
//   i_start     encode and send i_data_in; accepted only while o_ready=1
//   o_ready     idle and able to accept i_start
//   o_data_out  serial codeword bit (0 when o_valid=0)
//   o_valid     o_data_out carries a codeword bit
//   o_last      final bit of the codeword
//   o_sel_err   one-cycle pulse when i_start is seen with i_code_sel=11
module hamming_encoder_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MSG_WIDTH  = DATA_WIDTH - 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [MSG_WIDTH-1:0] i_data_in,
    input  logic [1:0]           i_code_sel,
    input  logic                 i_start,
    output logic                 o_ready,
    output logic                 o_data_out,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_sel_err
);

    typedef enum logic {StIdle, StShift} state_t;

    // Encode msg into an n-bit extended Hamming codeword (n = 8, 16 or 32).
    function automatic logic [31:0] f_encode(input logic [MSG_WIDTH-1:0] msg,
                                             input logic [5:0]           n);
        logic [31:0] cw;
        logic [4:0]  di;
        logic [5:0]  pos;
        logic [5:0]  pk;
        logic        par;
        cw = '0;
        di = '0;
        // Data placement: every non-power-of-two position below n.
        for (int p = 3; p < 32; p++) begin
            pos = 6'(p);
            if ((pos < n) && ((pos & (pos - 6'd1)) != 6'd0)) begin
                cw[pos[4:0]] = msg[di];
                di           = di + 5'd1;
            end
        end
        // Parity bit 2^k covers every other position with bit k set.
        for (int k = 0; k < 5; k++) begin
            pk = 6'd1 << k;
            if (pk < n) begin
                par = 1'b0;
                for (int p = 1; p < 32; p++) begin
                    pos = 6'(p);
                    if ((pos < n) && ((pos & pk) != 6'd0) && (pos != pk)) begin
                        par = par ^ cw[pos[4:0]];
                    end
                end
                cw[pk[4:0]] = par;
            end
        end
        cw[0] = ^cw[31:1];
        return cw;
    endfunction

    state_t      r_state;
    logic [31:0] r_shift;
    logic [4:0]  r_cnt;
    logic [4:0]  r_last_idx;
    logic        r_data_out;
    logic        r_valid;
    logic        r_last;
    logic        r_sel_err;

    state_t      w_state_next;
    logic [31:0] w_shift_next;
    logic [4:0]  w_cnt_next;
    logic [4:0]  w_last_idx_next;
    logic        w_data_out_next;
    logic        w_valid_next;
    logic        w_last_next;
    logic        w_sel_err_next;

    logic [31:0] w_cw;
    logic [4:0]  w_len_m1;

    always_comb begin
        w_cw     = '0;
        w_len_m1 = '0;
        case (i_code_sel)
            2'b00: begin
                w_cw     = f_encode(i_data_in, 6'd8);
                w_len_m1 = 5'd7;
            end
            2'b01: begin
                w_cw     = f_encode(i_data_in, 6'd16);
                w_len_m1 = 5'd15;
            end
            2'b10: begin
                w_cw     = f_encode(i_data_in, 6'd32);
                w_len_m1 = 5'd31;
            end
            default: begin
                w_cw     = '0;
                w_len_m1 = '0;
            end
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_cnt_next      = r_cnt;
        w_last_idx_next = r_last_idx;
        w_data_out_next = 1'b0;
        w_valid_next    = 1'b0;
        w_last_next     = 1'b0;
        w_sel_err_next  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (i_code_sel == 2'b11) begin
                        w_sel_err_next = 1'b1;
                    end else begin
                        // Bit 0 goes straight to the output register; the rest
                        // waits in the shifter.
                        w_state_next    = StShift;
                        w_shift_next    = {1'b0, w_cw[31:1]};
                        w_cnt_next      = '0;
                        w_last_idx_next = w_len_m1;
                        w_data_out_next = w_cw[0];
                        w_valid_next    = 1'b1;
                    end
                end
            end
            StShift: begin
                // r_cnt is the index of the bit currently on o_data_out.
                if (r_cnt == r_last_idx) begin
                    w_state_next = StIdle;
                    w_shift_next = '0;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next      = r_cnt + 5'd1;
                    w_data_out_next = r_shift[0];
                    w_shift_next    = {1'b0, r_shift[31:1]};
                    w_valid_next    = 1'b1;
                    w_last_next     = ((r_cnt + 5'd1) == r_last_idx);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_last_idx <= '0;
            r_data_out <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_sel_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_cnt      <= w_cnt_next;
            r_last_idx <= w_last_idx_next;
            r_data_out <= w_data_out_next;
            r_valid    <= w_valid_next;
            r_last     <= w_last_next;
            r_sel_err  <= w_sel_err_next;
        end
    end

    assign o_ready    = (r_state == StIdle) && !i_rst;
    assign o_data_out = r_data_out;
    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_sel_err  = r_sel_err;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
`timescale 1ns/1ps
// Self-checking bench for hamming_encoder_tx. A queue-based model predicts every
// output each cycle; received frames are also decoded (syndrome, parity, payload).
module tb_hamming_encoder_tx;

    logic        clk;
    logic        rst;
    logic [25:0] data_in;
    logic [1:0]  code_sel;
    logic        start;
    logic        ready;
    logic        data_out;
    logic        valid;
    logic        last;
    logic        sel_err;

    int checks = 0;
    int errors = 0;
    int frames = 0;

    hamming_encoder_tx dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_data_in  (data_in),
        .i_code_sel (code_sel),
        .i_start    (start),
        .o_ready    (ready),
        .o_data_out (data_out),
        .o_valid    (valid),
        .o_last     (last),
        .o_sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int code_len(input logic [1:0] s);
        return (s == 2'd0) ? 8 : (s == 2'd1) ? 16 : 32;
    endfunction

    // Reference encoder: parity bits are chosen so that the XOR of the indices of
    // all set bits is zero, then bit 0 evens the overall parity.
    function automatic logic [31:0] ref_code(input logic [25:0] d, input logic [1:0] s);
        int          n;
        int          di;
        int          syn;
        logic [31:0] cw;
        n   = code_len(s);
        cw  = '0;
        di  = 0;
        syn = 0;
        for (int p = 3; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[5'(p)] = d[5'(di)];
                if (d[5'(di)]) syn = syn ^ p;
                di++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (((1 << k) < n) && (((syn >> k) & 1) != 0)) cw[5'(1 << k)] = 1'b1;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    // Expected 32-bit codeword for a single data bit j, from first principles.
    function automatic logic [31:0] single_bit_code(input int j);
        int          p;
        int          cnt;
        int          ones;
        logic [31:0] e;
        p   = 0;
        cnt = 0;
        for (int q = 3; q < 32; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == j) p = q;
                cnt++;
            end
        end
        e    = '0;
        e[5'(p)] = 1'b1;
        ones = 1;
        for (int k = 0; k < 5; k++) begin
            if (((p >> k) & 1) != 0) begin
                e[5'(1 << k)] = 1'b1;
                ones++;
            end
        end
        if ((ones % 2) == 1) e[0] = 1'b1;
        return e;
    endfunction

    task automatic check_decode(input logic [31:0] w, input int len,
                                input logic [25:0] msg, input logic [1:0] s);
        int          n;
        int          syn;
        int          di;
        logic [25:0] got;
        logic [25:0] mask;
        n   = code_len(s);
        syn = 0;
        di  = 0;
        got = '0;
        for (int p = 1; p < 32; p++) begin
            if (p < len && w[5'(p)]) syn = syn ^ p;
        end
        for (int p = 3; p < 32; p++) begin
            if (p < len && ((p & (p - 1)) != 0)) begin
                if (di < 26) got[5'(di)] = w[5'(p)];
                di++;
            end
        end
        mask = (s == 2'd0) ? 26'hF : (s == 2'd1) ? 26'h7FF : 26'h3FFFFFF;
        chk("rx_len", len, n);
        chk("rx_syndrome", syn, 0);
        chk("rx_parity", {31'd0, ^w}, 0);
        chk("rx_payload", {6'd0, got}, {6'd0, msg & mask});
    endtask

    // ---------------- model + compare (runs on every falling edge) ----------------
    bit          armed = 1'b0;
    bit          m_idle = 1'b1;
    bit          q_bits[$];
    logic        e_valid = 1'b0;
    logic        e_bit = 1'b0;
    logic        e_last = 1'b0;
    logic        e_sel_err = 1'b0;
    logic [25:0] m_msg = '0;
    logic [1:0]  m_sel = '0;
    logic [31:0] rx_word = '0;
    int          rx_len = 0;

    always @(negedge clk) begin
        logic [31:0] cw;
        int          n;
        if (armed) begin
            chk("outputs{ready,valid,data,last,sel_err}",
                {27'd0, ready, valid, data_out, last, sel_err},
                {27'd0, (m_idle && !rst), e_valid, e_bit, e_last, e_sel_err});
            if (valid) begin
                if (rx_len == 0) rx_word = '0;
                if (rx_len < 32) rx_word[5'(rx_len)] = data_out;
                rx_len++;
                if (last) begin
                    check_decode(rx_word, rx_len, m_msg, m_sel);
                    frames++;
                    rx_len = 0;
                end
            end else begin
                rx_len = 0;
            end
        end
        // Advance the model using the inputs the next rising edge will sample.
        e_sel_err = 1'b0;
        if (rst) begin
            m_idle  = 1'b1;
            q_bits.delete();
            e_valid = 1'b0;
            e_bit   = 1'b0;
            e_last  = 1'b0;
            armed   = 1'b1;
        end else if (m_idle) begin
            e_valid = 1'b0;
            e_bit   = 1'b0;
            e_last  = 1'b0;
            if (start) begin
                if (code_sel == 2'b11) begin
                    e_sel_err = 1'b1;
                end else begin
                    cw = ref_code(data_in, code_sel);
                    n  = code_len(code_sel);
                    for (int i = 0; i < n; i++) q_bits.push_back(cw[5'(i)]);
                    m_msg   = data_in;
                    m_sel   = code_sel;
                    e_bit   = q_bits.pop_front();
                    e_valid = 1'b1;
                    m_idle  = 1'b0;
                end
            end
        end else begin
            if (q_bits.size() == 0) begin
                m_idle  = 1'b1;
                e_valid = 1'b0;
                e_bit   = 1'b0;
                e_last  = 1'b0;
            end else begin
                e_bit   = q_bits.pop_front();
                e_valid = 1'b1;
                e_last  = (q_bits.size() == 0);
            end
        end
    end

    // Call at posedge+2 with the DUT idle; returns at posedge+2 after the frame.
    task automatic send(input logic [25:0] d, input logic [1:0] s,
                        output logic [31:0] w, output int len);
        bit done;
        done     = 1'b0;
        data_in  = d;
        code_sel = s;
        start    = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        w     = '0;
        len   = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (valid) begin
                if (len < 32) w[5'(len)] = data_out;
                len++;
                if (last) done = 1'b1;
            end
        end
        chk("send_completed", {31'd0, done}, 1);
        @(posedge clk); #2;
    endtask

    initial begin
        logic [31:0] w;
        int          len;
        int          bits;
        int          quiet;
        logic [25:0] d;
        logic [1:0]  s;

        rst      = 1'b1;
        start    = 1'b0;
        data_in  = '0;
        code_sel = 2'b00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {27'd0, ready, valid, data_out, last, sel_err}, 32'b10000);
        @(posedge clk); #2;

        // 1: 4-bit message 1011 -> 8'hAA
        send(26'b1011, 2'b00, w, len);
        chk("t1_len", len, 8);
        chk("t1_code", w, 32'h0000_00AA);
        chk("t1_ready_after", {31'd0, ready}, 1);

        // 2: 11 ones with garbage above -> 16'hFFFF
        send({15'h2ABC, 11'h7FF}, 2'b01, w, len);
        chk("t2_len", len, 16);
        chk("t2_code", w, 32'h0000_FFFF);

        // 3: zero word and every single data bit of the 32-bit code
        send(26'd0, 2'b10, w, len);
        chk("t3_zero_code", w, 32'd0);
        chk("t3_zero_len", len, 32);
        for (int j = 0; j < 26; j++) begin
            d = 26'd1 << j;
            send(d, 2'b10, w, len);
            chk("t3_single_dut", w, ref_code(d, 2'b10));
            chk("t3_single_model", ref_code(d, 2'b10), single_bit_code(j));
        end

        // Random frames in all legal modes
        repeat (20) begin
            d = 26'($urandom);
            s = 2'($urandom_range(0, 2));
            send(d, s, w, len);
            chk("rand_code", w, ref_code(d, s));
        end

        // 4: start held every cycle with changing data
        start = 1'b1;
        repeat (300) begin
            data_in  = 26'($urandom);
            code_sel = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            @(posedge clk); #2;
        end
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (ready) break;
            @(posedge clk); #2;
        end
        chk("t4_back_to_idle", {31'd0, ready}, 1);

        // 5: reset in the middle of a 32-bit frame
        data_in  = 26'($urandom);
        code_sel = 2'b10;
        start    = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        bits  = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (valid) bits++;
            if (bits == 11) break;
        end
        chk("t5_reached_bit10", bits, 11);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_after_reset", {29'd0, valid, data_out, ready}, 32'b001);
        quiet = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid) quiet++;
        end
        chk("t5_no_more_bits", quiet, 0);
        @(posedge clk); #2;
        d = 26'($urandom);
        send(d, 2'b10, w, len);
        chk("t5_restart_code", w, ref_code(d, 2'b10));
        chk("t5_restart_len", len, 32);

        // 6: reserved code_sel
        data_in  = 26'($urandom);
        code_sel = 2'b11;
        start    = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("t6_pulse", {29'd0, sel_err, valid, ready}, 32'b101);
        @(negedge clk);
        chk("t6_pulse_end", {29'd0, sel_err, valid, ready}, 32'b001);
        @(posedge clk); #2;

        chk("frames_decoded_min", {31'd0, (frames >= 50)}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
